// File: rtl/hpi_pkg.sv
// hpi_pkg: shared types and constants for the HPI master controller.
//   hpi_state_t : bus-cycle FSM states
//   HPI_REG_*   : HPI register addresses (Avalon word address maps 1:1)
//   HPI_CNT_W   : width of the shared phase down-counter
//   cnt_load()  : counter load value for an N-cycle phase
package hpi_pkg;

    localparam int HPI_CNT_W = 4;

    localparam logic [1:0] HPI_REG_DATA    = 2'd0;
    localparam logic [1:0] HPI_REG_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_REG_ADDRESS = 2'd2;
    localparam logic [1:0] HPI_REG_STATUS  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE,
        RECOVER
    } hpi_state_t;

    // A phase of N cycles loads N-1 and exits when the counter reads 0.
    function automatic logic [HPI_CNT_W-1:0] cnt_load(input int unsigned n);
        return HPI_CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/hpi_master_ctrl_if.sv
// hpi_master_ctrl_if: Avalon-MM slave front end plus HPI pin group.
//   slave  modport : seen by hpi_master_ctrl (Avalon inputs, HPI pin outputs)
//   master modport : seen by the Avalon master / board model driving it
//   Avalon : address, chipselect, read, write, writedata, readdata, waitrequest
//   HPI    : hpi_addr, hpi_data_out, hpi_data_oe, hpi_data_in, hpi_cs_n,
//            hpi_rd_n, hpi_wr_n, hpi_int, irq
interface hpi_master_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [1:0]  hpi_addr;
    logic [15:0] hpi_data_out;
    logic        hpi_data_oe;
    logic [15:0] hpi_data_in;
    logic        hpi_cs_n;
    logic        hpi_rd_n;
    logic        hpi_wr_n;
    logic        hpi_int;
    logic        irq;

    modport slave (
        input  address, chipselect, read, write, writedata, hpi_data_in, hpi_int,
        output readdata, waitrequest, hpi_addr, hpi_data_out, hpi_data_oe,
               hpi_cs_n, hpi_rd_n, hpi_wr_n, irq
    );

    modport master (
        output address, chipselect, read, write, writedata, hpi_data_in, hpi_int,
        input  readdata, waitrequest, hpi_addr, hpi_data_out, hpi_data_oe,
               hpi_cs_n, hpi_rd_n, hpi_wr_n, irq
    );
endinterface

// File: rtl/hpi_int_sync.sv
// hpi_int_sync: 2-flop synchronizer for the asynchronous HPI interrupt.
//   clk, rst_n : clock, async active-low reset (flops reset to 0)
//   d_i        : asynchronous input
//   q_o        : synchronized level, 2-cycle latency
module hpi_int_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], d_i};
    end

    assign q_o = sync_q[1];
endmodule

// File: rtl/hpi_master_ctrl.sv
// hpi_master_ctrl: turns single 16-bit Avalon-MM read/write requests into
// timed CY7C67200 HPI bus cycles (setup / strobe / hold / done / recover).
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : Avalon request/response and HPI pins, see hpi_master_ctrl_if
// Optional: define HPI_INT_SYNC_EN to route hpi_int through a 2-flop
// synchronizer onto irq; otherwise irq is tied low and hpi_int is ignored.
module hpi_master_ctrl
    import hpi_pkg::*;
#(
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned STROBE_CYC  = 4,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned RECOVER_CYC = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    hpi_master_ctrl_if.slave bus
);
    hpi_state_t           state_q, state_d;
    logic [HPI_CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]           addr_q, addr_d;
    logic [15:0]          wdata_q, wdata_d;
    logic [15:0]          rdata_q, rdata_d;
    logic                 is_wr_q, is_wr_d;
    logic                 req, busy;

    assign req = bus.chipselect & (bus.read | bus.write);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            is_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            is_wr_q <= is_wr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        is_wr_d = is_wr_q;
        case (state_q)
            IDLE: if (req) begin
                state_d = SETUP;
                cnt_d   = cnt_load(SETUP_CYC);
                addr_d  = bus.address;
                wdata_d = bus.writedata[15:0];
                is_wr_d = bus.write;            // write wins over read
            end
            SETUP: if (cnt_q == '0) begin
                state_d = STROBE;
                cnt_d   = cnt_load(STROBE_CYC);
            end else cnt_d = cnt_q - 1'b1;
            STROBE: if (cnt_q == '0) begin
                // Sample on the last low strobe cycle, just before rd_n rises.
                if (!is_wr_q) rdata_d = bus.hpi_data_in;
                state_d = HOLD;
                cnt_d   = cnt_load(HOLD_CYC);
            end else cnt_d = cnt_q - 1'b1;
            HOLD: if (cnt_q == '0) begin
                state_d = DONE;
                cnt_d   = '0;
            end else cnt_d = cnt_q - 1'b1;
            // Fixed one-cycle ack; a dropped request simply goes unanswered.
            DONE: begin
                state_d = RECOVER;
                cnt_d   = cnt_load(RECOVER_CYC);
            end
            RECOVER: if (cnt_q == '0) state_d = IDLE;
                     else cnt_d = cnt_q - 1'b1;
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pins decode straight from state so an async reset releases them at once.
    assign busy             = (state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD);
    assign bus.hpi_cs_n     = ~busy;
    assign bus.hpi_rd_n     = ~((state_q == STROBE) & ~is_wr_q);
    assign bus.hpi_wr_n     = ~((state_q == STROBE) &  is_wr_q);
    assign bus.hpi_data_oe  = busy & is_wr_q;
    assign bus.hpi_addr     = addr_q;
    assign bus.hpi_data_out = wdata_q;
    assign bus.readdata     = {16'h0000, rdata_q};
    assign bus.waitrequest  = req & (state_q != DONE);

    logic unused_wdata_hi;
    assign unused_wdata_hi = &{1'b0, bus.writedata[31:16]};

`ifdef HPI_INT_SYNC_EN
    hpi_int_sync u_int_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d_i   (bus.hpi_int),
        .q_o   (bus.irq)
    );
`else
    logic unused_hpi_int;
    assign unused_hpi_int = &{1'b0, bus.hpi_int};
    assign bus.irq        = 1'b0;
`endif

endmodule

// File: tb/tb_hpi_master_ctrl.sv
module tb_hpi_master_ctrl;
    localparam int S = 1, T = 4, H = 1, R = 2;
    localparam int D = S + T + H + 1;   // done cycle after acceptance

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    hpi_master_ctrl_if bus();

    hpi_master_ctrl #(
        .SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H), .RECOVER_CYC(R)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [1:0]  addr;
        logic [15:0] wdata;
        logic [31:0] exp_rd;
        int          k;
        bit          first;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0, errors = 0;
    logic [15:0] model_rd = 16'h0;
    bit          next_first = 1'b1;
    bit          mon_en = 1'b0;
    int          irq_bad = 0, bad_idle = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    // Acceptance-to-acceptance spacing: master re-requests k cycles after the
    // ack cycle, but the controller cannot accept before recovery ends.
    function automatic int gap_exp(input int k);
        return (D + 1 + k > D + R + 1) ? D + 1 + k : D + R + 1;
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after the ack.
    task automatic xfer(input bit rd, input bit wr, input logic [1:0] a,
                        input logic [15:0] wd, input logic [15:0] dev, input int k);
        exp_t e;
        logic [15:0] hi;
        int n;
        if (k > 0) begin
            repeat (k) @(posedge clk);
            #1;
        end
        if (!wr) model_rd = dev;
        e.is_wr = wr; e.addr = a; e.wdata = wd; e.exp_rd = {16'h0, model_rd};
        e.k = k; e.first = next_first;
        next_first = 1'b0;
        sb.push_back(e);
        hi = 16'($urandom());
        bus.hpi_data_in = dev;
        bus.address     = a;
        bus.writedata   = {hi, wd};
        bus.chipselect  = 1'b1;
        bus.read        = rd;
        bus.write       = wr;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.waitrequest && n < 60);
        if (bus.waitrequest) begin
            errors++;
            $display("FAIL ack_timeout: waitrequest still high after %0d cycles, required low", n);
            finish_sim();
        end
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = 2'($urandom());
    endtask

    // Monitor / scoreboard: tracks each cs_n-low window and checks it when
    // the controller acks.
    initial begin
        int cyc = 0, fall_cyc = 0, cs_cnt = 0, rd_cnt = 0, wr_cnt = 0;
        int strb_first = -1, bad_bus = 0;
        logic prev_cs_n = 1'b1;
        logic p1 = 1'b0, p2 = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en && reset_n) begin
                if (!bus.hpi_cs_n) begin
                    if (sb.size() == 0) bad_idle++;
                    else begin
                        if (prev_cs_n) begin
                            if (!sb[0].first) chk("accept_gap", cyc - fall_cyc, gap_exp(sb[0].k));
                            fall_cyc = cyc; cs_cnt = 0; rd_cnt = 0; wr_cnt = 0;
                            strb_first = -1; bad_bus = 0;
                        end
                        cs_cnt++;
                        if (!bus.hpi_rd_n) rd_cnt++;
                        if (!bus.hpi_wr_n) wr_cnt++;
                        if ((!bus.hpi_rd_n || !bus.hpi_wr_n) && strb_first < 0)
                            strb_first = cyc - fall_cyc;
                        if (bus.hpi_addr !== sb[0].addr) bad_bus++;
                        if (bus.hpi_data_oe !== sb[0].is_wr) bad_bus++;
                        if (sb[0].is_wr && bus.hpi_data_out !== sb[0].wdata) bad_bus++;
                    end
                end else if (bus.hpi_data_oe || !bus.hpi_rd_n || !bus.hpi_wr_n) begin
                    bad_idle++;
                end
                if (bus.chipselect && (bus.read || bus.write) && !bus.waitrequest) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_ack: ack at cycle %0d, required none", cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("readdata", bus.readdata, e.exp_rd);
                        chk("ack_latency", cyc - fall_cyc, S + T + H);
                        chk("cs_low_cycles", cs_cnt, S + T + H);
                        chk("rd_strobe_cycles", rd_cnt, e.is_wr ? 0 : T);
                        chk("wr_strobe_cycles", wr_cnt, e.is_wr ? T : 0);
                        chk("strobe_offset", strb_first, S);
                        chk("bus_bad_cycles", bad_bus, 0);
                    end
                end
                prev_cs_n = bus.hpi_cs_n;
            end else begin
                prev_cs_n = 1'b1;
            end
            // irq reference: level of hpi_int two clocks earlier, or always 0.
            if (!reset_n) begin
                p1 = 1'b0; p2 = 1'b0;
                if (bus.irq !== 1'b0) irq_bad++;
            end else begin
`ifdef HPI_INT_SYNC_EN
                if (bus.irq !== p2) irq_bad++;
`else
                if (bus.irq !== 1'b0) irq_bad++;
`endif
                p2 = p1;
                p1 = bus.hpi_int;
            end
        end
    end

    // Interrupt line from the device toggles randomly throughout.
    initial begin
        bus.hpi_int = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 3) == 0) bus.hpi_int = ~bus.hpi_int;
        end
    end

    initial begin
        int n;
        bus.address = 2'd0; bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
        bus.writedata = 32'h0; bus.hpi_data_in = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", bus.hpi_cs_n, 1);
        chk("rst_rd_n", bus.hpi_rd_n, 1);
        chk("rst_wr_n", bus.hpi_wr_n, 1);
        chk("rst_oe", bus.hpi_data_oe, 0);
        chk("rst_addr", bus.hpi_addr, 0);
        chk("rst_data_out", bus.hpi_data_out, 0);
        chk("rst_readdata", bus.readdata, 0);
        chk("rst_irq", bus.irq, 0);
        chk("rst_waitrequest", bus.waitrequest, 0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        @(posedge clk);
        #1;

        // Directed: write, read, back-to-back writes, read+write together.
        xfer(0, 1, 2'd2, 16'h1000, 16'h0000, 0);
        xfer(1, 0, 2'd0, 16'h0000, 16'hBEEF, 2);
        xfer(0, 1, 2'd2, 16'h2222, 16'h0000, 0);
        xfer(0, 1, 2'd0, 16'h3333, 16'h0000, 0);
        xfer(1, 1, 2'd1, 16'h55AA, 16'h1234, 1);
        chk("readdata_hold_after_writes", bus.readdata, 32'h0000BEEF);

        // Reset pulse in the middle of a write strobe.
        mon_en = 1'b0;
        bus.address = 2'd3; bus.writedata = 32'h0000A5A5;
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.read = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.hpi_wr_n && n < 20);
        chk("reset_test_reached_strobe", bus.hpi_wr_n, 0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_cs_n", bus.hpi_cs_n, 1);
        chk("midrst_wr_n", bus.hpi_wr_n, 1);
        chk("midrst_rd_n", bus.hpi_rd_n, 1);
        chk("midrst_oe", bus.hpi_data_oe, 0);
        bus.chipselect = 1'b0; bus.write = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n    = 1'b1;
        model_rd   = 16'h0;
        next_first = 1'b1;
        mon_en     = 1'b1;
        xfer(1, 0, 2'd0, 16'h0000, 16'hC0DE, 0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = $urandom_range(0, 2);
            xfer(sel != 1, sel != 0, 2'($urandom()), 16'($urandom()), 16'($urandom()),
                 $urandom_range(0, 3));
        end

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        chk("idle_bus_activity", bad_idle, 0);
        chk("irq_model_mismatches", irq_bad, 0);
        finish_sim();
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        finish_sim();
    end
endmodule
